// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment bit positions, glyph patterns and shared types for
// the 7-segment scan decoder.
package seven_seg_pkg;
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] nib_t;

    localparam seg_t GLYPH_0    = 7'h3F;
    localparam seg_t GLYPH_1    = 7'h06;
    localparam seg_t GLYPH_2    = 7'h5B;
    localparam seg_t GLYPH_3    = 7'h4F;
    localparam seg_t GLYPH_4    = 7'h66;
    localparam seg_t GLYPH_5    = 7'h6D;
    localparam seg_t GLYPH_6    = 7'h7D;
    localparam seg_t GLYPH_7    = 7'h07;
    localparam seg_t GLYPH_8    = 7'h7F;
    localparam seg_t GLYPH_9    = 7'h6F;
    localparam seg_t GLYPH_A    = 7'h77;
    localparam seg_t GLYPH_B    = 7'h7C;
    localparam seg_t GLYPH_C    = 7'h39;
    localparam seg_t GLYPH_D    = 7'h5E;
    localparam seg_t GLYPH_E    = 7'h79;
    localparam seg_t GLYPH_F    = 7'h71;
    localparam seg_t GLYPH_DASH = seg_t'(1 << SEG_G);

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;
endpackage

// File: rtl/seven_seg_to_hex.sv
// seven_seg_to_hex: maps a segment pattern back to its hex nibble; hit is low
// for any pattern that is not one of the sixteen hex glyphs.
module seven_seg_to_hex
    import seven_seg_pkg::*;
(
    input  seg_t       seg,
    output nib_t       nib,
    output logic       hit
);
    always_comb begin
        hit = 1'b1;
        nib = 4'h0;
        case (seg)
            GLYPH_0: nib = 4'h0;
            GLYPH_1: nib = 4'h1;
            GLYPH_2: nib = 4'h2;
            GLYPH_3: nib = 4'h3;
            GLYPH_4: nib = 4'h4;
            GLYPH_5: nib = 4'h5;
            GLYPH_6: nib = 4'h6;
            GLYPH_7: nib = 4'h7;
            GLYPH_8: nib = 4'h8;
            GLYPH_9: nib = 4'h9;
            GLYPH_A: nib = 4'hA;
            GLYPH_B: nib = 4'hB;
            GLYPH_C: nib = 4'hC;
            GLYPH_D: nib = 4'hD;
            GLYPH_E: nib = 4'hE;
            GLYPH_F: nib = 4'hF;
            default: hit = 1'b0;
        endcase
    end
endmodule

// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder: debounces each scan slot of a multiplexed 7-segment
// bus, keeps the decoded nibble per digit and reports changes on a stream.
module seven_seg_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 8,
    parameter int CW         = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [6:0]        seg_in,
    input  logic [NDIG-1:0]   dig_sel,
    output logic [4*NDIG-1:0] digits,
    output logic [NDIG-1:0]   digit_ok,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_idx,
    output logic [3:0]        out_val,
    output logic              bad_pat,
    output logic              overrun,
    input  logic              clr_flags
);
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    seg_t              prev_seg_q;
    logic [NDIG-1:0]   prev_sel_q;
    logic [4*NDIG-1:0] digits_q, digits_d;
    logic [NDIG-1:0]   ok_q, ok_d;
    logic              valid_q, valid_d;
    logic [2:0]        idx_q, idx_d;
    nib_t              val_q, val_d;
    logic              bad_q, bad_d;
    logic              ovr_q, ovr_d;

    nib_t       nib, cur_nib;
    logic       hit, cur_ok, onehot, same, accept, ev, pop, load;
    logic [2:0] sel_idx;

    seven_seg_to_hex u_dec (.seg(seg_in), .nib(nib), .hit(hit));

    assign onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - NDIG'(1))) == '0);
    assign same   = (seg_in == prev_seg_q) && (dig_sel == prev_sel_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                state_d = onehot ? SETTLE : IDLE;
            end
            SETTLE, HELD: begin
                if (!same) begin
                    state_d = onehot ? SETTLE : IDLE;
                    cnt_d   = onehot ? CW'(1) : '0;
                end else if (state_q == SETTLE) begin
                    if (cnt_q == CW'(STABLE_CYC - 1)) begin
                        accept  = 1'b1;
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_idx  = '0;
        cur_nib  = '0;
        cur_ok   = 1'b0;
        digits_d = digits_q;
        ok_d     = ok_q;
        for (int k = 0; k < NDIG; k++) begin
            if (dig_sel[k]) begin
                sel_idx = 3'(k);
                cur_nib = digits_q[4*k +: 4];
                cur_ok  = ok_q[k];
            end
            if (accept && dig_sel[k]) begin
                ok_d[k] = hit;
                if (hit) digits_d[4*k +: 4] = nib;
            end
        end
        pop     = valid_q && out_ready;
        ev      = accept && hit && (!cur_ok || cur_nib != nib);
        load    = ev && (!valid_q || pop);
        valid_d = load || (valid_q && !pop);
        idx_d   = load ? sel_idx : idx_q;
        val_d   = load ? nib : val_q;
        // A set condition in the same cycle as clr_flags takes priority.
        bad_d   = (accept && !hit) || (bad_q && !clr_flags);
        ovr_d   = (ev && valid_q && !pop) || (ovr_q && !clr_flags);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            prev_seg_q <= '0;
            prev_sel_q <= '0;
            digits_q   <= '0;
            ok_q       <= '0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            val_q      <= '0;
            bad_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prev_seg_q <= seg_in;
            prev_sel_q <= dig_sel;
            digits_q   <= digits_d;
            ok_q       <= ok_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            val_q      <= val_d;
            bad_q      <= bad_d;
            ovr_q      <= ovr_d;
        end
    end

    assign digits    = digits_q;
    assign digit_ok  = ok_q;
    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign out_val   = val_q;
    assign bad_pat   = bad_q;
    assign overrun   = ovr_q;
endmodule

// File: doc/seven_seg_scan_decoder.md
Name: seven_seg_scan_decoder

Overview:
- Inverse of the hex-to-7-segment encoder: watches a multiplexed 7-segment display bus (segment lines plus one-hot digit select) and recovers the 4-bit hex value shown on each digit.
- Used to sniff or verify display output from external boards or our own display drivers.
- Debounces each scan slot, decodes the segment pattern to a nibble, holds a per-digit register file, and emits change events on a valid/ready stream.

Parameters:
- NDIG, 4, number of multiplexed digits (one-hot select width), 1..8.
- STABLE_CYC, 8, consecutive identical cycles required before a sample is accepted, 2..255.
- CW, 8, width of the stability counter; must satisfy 2**CW > STABLE_CYC.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- seg_in  in  7  segment lines, active-high; bit0=a … bit6=g, same mapping as the encoder. Already synchronised upstream.
- dig_sel  in  NDIG  digit select, active-high, expected one-hot or all-zero. Already synchronised upstream.
- digits  out  4*NDIG  decoded nibble per digit; digit i at [4i+3:4i].
- digit_ok  out  NDIG  digit i holds a valid decode.
- out_valid  out  1  change event available.
- out_ready  in  1  consumer accepts the event.
- out_idx  out  3  digit index of the event.
- out_val  out  4  nibble of the event.
- bad_pat  out  1  sticky: a stable, unrecognised segment pattern was seen.
- overrun  out  1  sticky: an event was dropped because the buffer was full.
- clr_flags  in  1  synchronous clear of bad_pat and overrun.

Behaviour:
- Reset values: all outputs 0, internal counter 0, state IDLE.
- Decode table (seg_in → nibble):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7
  - 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F
  - Any other pattern, including 40 (dash) and 00 (blank), is unrecognised.
- Registered copies prev_seg and prev_sel are updated every cycle.
- FSM states: IDLE, SETTLE, HELD.
  - IDLE: dig_sel is zero or not one-hot. Counter is cleared. Go to SETTLE when dig_sel becomes one-hot.
  - SETTLE: while seg_in==prev_seg and dig_sel==prev_sel, increment counter.
    - Any change of either input: counter=1 and stay in SETTLE (if dig_sel is still one-hot), else go to IDLE.
    - When counter reaches STABLE_CYC-1 with inputs still equal: accept the sample this cycle and go to HELD.
  - HELD: no further accepts until seg_in or dig_sel changes. On change, go to SETTLE (counter=1) or IDLE, using the same rule as SETTLE.
- On accept with a recognised pattern for digit i:
  - Write digits[i] and set digit_ok[i] on the next clock edge.
  - Generate an event if digit_ok[i] was 0 or the new value differs from the stored one.
- On accept with an unrecognised pattern:
  - Clear digit_ok[i]; leave digits[i] unchanged.
  - Set bad_pat.
  - Generate no event.
- Latency: first accept occurs exactly STABLE_CYC cycles after the first cycle a stable one-hot input is presented. Outputs are registered one cycle later.
- Output stream uses a one-entry buffer:
  - The event loads out_idx/out_val and asserts out_valid.
  - out_valid, out_idx and out_val stay stable until out_valid && out_ready.
  - Simultaneous pop and new event: the new event loads, and out_valid stays 1.
  - New event while the buffer is full and not popping: the new event is dropped, the buffered event is kept, and overrun is set. digits and digit_ok are still updated.
- clr_flags clears the sticky flags. If a set condition occurs in the same cycle, set wins.
- resetn asserted mid-settle or with an event pending: everything clears immediately (asynchronous); the event is lost.

Decomposition:
- Package seven_seg_pkg holds:
  - segment bit-position constants SEG_A..SEG_G;
  - 7-bit localparams for glyphs 0..F and dash;
  - typedef seg_t (logic [6:0]) and nib_t (logic [3:0]).
- Sub-module seven_seg_to_hex: combinational, seg_t in → nib_t out plus a hit flag, implementing the decode table.
- FSM, counter, register file and output buffer stay in the top module.

Test Plan:
- Reset; hold dig_sel=0001 and seg_in=5B for 8 cycles → on the 9th edge, digits[3:0]=2, digit_ok=0001, out_valid=1, out_idx=0, out_val=2.
- Scan 4 digits (showing 1, A, F, 0), 20 cycles each, with out_ready=1 → four events in order (idx 0..3; values 1, A, F, 0); digits=16'h0FA1. Rescanning the same values produces no events.
- Glitch: seg_in=7F for 5 cycles, then 6F for 8 cycles on digit 1 → single event with value 9; no event with value 8.
- seg_in=40 stable on digit 2 → bad_pat=1, digit_ok[2]=0, no event. clr_flags → bad_pat=0.
- out_ready=0; change digit 0 to 3, then digit 1 to 4 → the buffer holds idx0/3, overrun=1, digits[7:4]=4. Pulse out_ready together with a new event for digit 2 → buffer loads digit 2's event and out_valid stays 1.
- dig_sel=0011 (not one-hot) for 30 cycles → no accepts. Assert resetn low mid-SETTLE → all outputs return to 0 asynchronously.
